simd_divsqrt_unit: RTL and testbench

Multi-cycle, parametrised SIMD divide / modulo / square-root unit that executes the long-latency R-type vector ops (VDIV, VMOD, VSQRT) for the EX stage beside the single-cycle vector ALU. It accepts one operation through a valid/ready handshake and processes lanes sequentially through one shared shift-subtract core. It returns a full-width result with per-lane divide-by-zero flags. Widths 8/16/32/64 are selected by the WW field; the datapath width is a parameter.

---
 rtl/simd_alu_pkg.sv | 37 +++
 rtl/lane_divsqrt_core.sv | 86 ++++++++
 rtl/simd_divsqrt_unit.sv | 165 ++++++++++++++++
 tb/tb_simd_divsqrt_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
//------------------------------------------------------------------------------
// Module      : simd_alu_pkg
// Description : Shared opcode/width encodings and FSM state type for the
//               vector ALU and the divide/sqrt unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package simd_alu_pkg;

    localparam logic [5:0] c_OP_VDIV  = 6'b001110;
    localparam logic [5:0] c_OP_VMOD  = 6'b001111;
    localparam logic [5:0] c_OP_VSQRT = 6'b010010;

    localparam logic [1:0] c_WW_8  = 2'b00;
    localparam logic [1:0] c_WW_16 = 2'b01;
    localparam logic [1:0] c_WW_32 = 2'b10;
    localparam logic [1:0] c_WW_64 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int ww_bits(input logic [1:0] ww);
        return 8 << ww;
    endfunction

    function automatic int lane_count(input logic [1:0] ww, input int data_w);
        return data_w / ww_bits(ww);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lane_divsqrt_core.sv
//------------------------------------------------------------------------------
// Module      : lane_divsqrt_core
// Description : Radix-2 restoring shift-subtract core for one lane: unsigned
//               divide (w steps) or integer square root (w/2 steps).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lane_divsqrt_core
    import simd_alu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_mode_sqrt,
    input  logic [1:0]        i_ww,
    input  logic [DATA_W-1:0] i_opa,
    input  logic [DATA_W-1:0] i_opb,
    output logic [DATA_W-1:0] o_quo,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_done
);

    localparam int CW = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_root;
    logic [DATA_W-1:0] r_b;
    logic [CW-1:0]     r_cnt;

    logic [CW-1:0]     w_width;
    logic [CW-1:0]     w_nsteps;
    logic [DATA_W:0]   w_min;
    logic [DATA_W:0]   w_sub;
    logic [DATA_W+1:0] w_diff;
    logic              w_ok;
    logic [DATA_W-1:0] w_q_next;
    logic [DATA_W-1:0] w_rem_next;
    logic [DATA_W-1:0] w_root_next;

    assign w_width  = CW'(ww_bits(i_ww));
    assign w_nsteps = i_mode_sqrt ? (w_width >> 1) : w_width;

    // Sqrt brings down two radicand bits and tries (4*root + 1); divide brings one bit and tries b.
    assign w_min = i_mode_sqrt ? {r_rem[DATA_W-2:0], r_q[DATA_W-1 -: 2]} : {r_rem, r_q[DATA_W-1]};
    assign w_sub = i_mode_sqrt ? {r_root[DATA_W-2:0], 2'b01} : {1'b0, r_b};

    assign w_diff      = {1'b0, w_min} - {1'b0, w_sub};
    assign w_ok        = ~w_diff[DATA_W+1];
    assign w_rem_next  = w_ok ? w_diff[DATA_W-1:0] : w_min[DATA_W-1:0];
    assign w_q_next    = i_mode_sqrt ? {r_q[DATA_W-3:0], 2'b00} : {r_q[DATA_W-2:0], w_ok};
    assign w_root_next = {r_root[DATA_W-2:0], w_ok};

    assign o_quo  = i_mode_sqrt ? w_root_next : w_q_next;
    assign o_rem  = w_rem_next;
    assign o_done = i_step && (r_cnt == w_nsteps - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            // Left-justify the lane so its MSB is consumed first.
            r_q    <= i_opa << (CW'(DATA_W) - w_width);
            r_rem  <= '0;
            r_root <= '0;
            r_b    <= i_opb;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_q    <= w_q_next;
            r_rem  <= w_rem_next;
            r_root <= w_root_next;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/simd_divsqrt_unit.sv
//------------------------------------------------------------------------------
// Module      : simd_divsqrt_unit
// Description : Multi-cycle SIMD VDIV/VMOD/VSQRT unit; lanes are processed one
//               at a time through a single shared shift-subtract core.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simd_divsqrt_unit
    import simd_alu_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int GRAN   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [1:0]        in_ww,
    input  logic [0:DATA_W-1] in_a,
    input  logic [0:DATA_W-1] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] out_result,
    output logic [0:GRAN-1]   out_dz,
    output logic              out_err
);

    localparam int SW = $clog2(DATA_W) + 1;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_err;
    logic              r_sqrt;
    logic              r_mod;
    logic [1:0]        r_ww;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic [GRAN-1:0]   r_dz;
    logic [SW-1:0]     r_idx;

    logic [SW-1:0]     w_width;
    logic [SW-1:0]     w_lanes;
    logic [SW-1:0]     w_shift;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_lane_a;
    logic [DATA_W-1:0] w_lane_b;
    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;
    logic [DATA_W-1:0] w_lane_res;
    logic [GRAN-1:0]   w_gmask;
    logic              w_core_done;
    logic              w_last;
    logic              w_illegal;

    // Lane 0 sits in the most significant bits, so its shift is the largest.
    assign w_width    = SW'(ww_bits(r_ww));
    assign w_lanes    = SW'(lane_count(r_ww, DATA_W));
    assign w_shift    = SW'(DATA_W) - (r_idx + SW'(1)) * w_width;
    assign w_mask     = {DATA_W{1'b1}} >> (SW'(DATA_W) - w_width);
    assign w_gmask    = {GRAN{1'b1}} >> (SW'(GRAN) - (w_width >> 3));
    assign w_lane_a   = (r_a >> w_shift) & w_mask;
    assign w_lane_b   = (r_b >> w_shift) & w_mask;
    assign w_lane_res = (r_mod ? w_rem : w_quo) & w_mask;
    assign w_last     = (r_idx == w_lanes - SW'(1));

    assign w_illegal = !((in_op == c_OP_VDIV) || (in_op == c_OP_VMOD) || (in_op == c_OP_VSQRT))
                       || (ww_bits(in_ww) > DATA_W);

    lane_divsqrt_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk         (clk),
        .rst         (reset),
        .i_load      (r_state == ST_LOAD),
        .i_step      (r_state == ST_ITER),
        .i_mode_sqrt (r_sqrt),
        .i_ww        (r_ww),
        .i_opa       (w_lane_a),
        .i_opb       (w_lane_b),
        .o_quo       (w_quo),
        .o_rem       (w_rem),
        .o_done      (w_core_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_sqrt      <= 1'b0;
            r_mod       <= 1'b0;
            r_ww        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_dz        <= '0;
            r_idx       <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_result    <= '0;
            r_dz        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_sqrt     <= (in_op == c_OP_VSQRT);
                        r_mod      <= (in_op == c_OP_VMOD);
                        r_ww       <= in_ww;
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_idx      <= '0;
                        r_result   <= '0;
                        r_dz       <= '0;
                        r_err      <= w_illegal;
                        r_state    <= w_illegal ? ST_DONE : ST_LOAD;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_LOAD: r_state <= ST_ITER;
                ST_ITER: begin
                    if (w_core_done) begin
                        r_result <= r_result | (w_lane_res << w_shift);
                        if (!r_sqrt && (w_lane_b == '0))
                            r_dz <= r_dz | (w_gmask << (w_shift >> 3));
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + SW'(1);
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_dz     = r_dz;
    assign out_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_simd_divsqrt_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_simd_divsqrt_unit
// Description : Self-checking bench for simd_divsqrt_unit against a lane-level
//               arithmetic reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_simd_divsqrt_unit;

    localparam int DATA_W = 64;
    localparam int GRAN   = 8;
    localparam logic [5:0] c_VDIV  = 6'b001110;
    localparam logic [5:0] c_VMOD  = 6'b001111;
    localparam logic [5:0] c_VSQRT = 6'b010010;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [5:0]        in_op     = '0;
    logic [1:0]        in_ww     = '0;
    logic [0:DATA_W-1] in_a      = '0;
    logic [0:DATA_W-1] in_b      = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_err;
    logic [0:DATA_W-1] out_result;
    logic [0:GRAN-1]   out_dz;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simd_divsqrt_unit #(
        .DATA_W (DATA_W),
        .GRAN   (GRAN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_ww      (in_ww),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dz     (out_dz),
        .out_err    (out_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0] r;
        r = '0;
        for (int k = 31; k >= 0; k--) begin
            logic [127:0] t;
            t = {64'd0, r | (64'd1 << k)};
            if (t * t <= {64'd0, x}) r = t[63:0];
        end
        return r;
    endfunction

    function automatic void model(input logic [5:0] op, input logic [1:0] ww,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output logic [7:0] dz,
                                  output logic err, output int lat);
        int w;
        int lanes;
        logic [63:0] mask;
        w     = 8 << ww;
        lanes = 64 / w;
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        res = '0;
        dz  = '0;
        err = 1'b0;
        if (op != c_VDIV && op != c_VMOD && op != c_VSQRT) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        lat = (op == c_VSQRT) ? lanes * (w / 2 + 1) + 1 : lanes * (w + 1) + 1;
        for (int i = 0; i < lanes; i++) begin
            int sh;
            logic [63:0] la, lb, lr;
            sh = 64 - (i + 1) * w;
            la = (a >> sh) & mask;
            lb = (b >> sh) & mask;
            if (op == c_VSQRT) begin
                lr = isqrt(la);
            end else if (lb == 0) begin
                lr = (op == c_VDIV) ? mask : la;
                for (int g = i * w / 8; g < (i + 1) * w / 8; g++) dz[7-g] = 1'b1;
            end else begin
                lr = (op == c_VDIV) ? la / lb : la % lb;
            end
            res |= (lr & mask) << sh;
        end
    endfunction

    task automatic start_op(input logic [5:0] op, input logic [1:0] ww,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        in_op = op; in_ww = ww; in_a = a; in_b = b; in_valid = 1'b1;
        for (int t = 0; t < 200 && !in_ready; t++) @(negedge clk);
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 300);
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("valid_drop", 64'(out_valid), 64'd0);
    endtask

    task automatic run_rand(input logic [5:0] op, input logic [1:0] ww,
                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] er;
        logic [7:0]  ed;
        logic        ee;
        int          el, lat;
        model(op, ww, a, b, er, ed, ee, el);
        start_op(op, ww, a, b);
        wait_result(lat);
        check($sformatf("lat op%h ww%0d", op, ww), 64'(lat), 64'(el));
        check($sformatf("res op%h ww%0d a%h b%h", op, ww, a, b), out_result, er);
        check($sformatf("dz op%h ww%0d", op, ww), 64'(out_dz), 64'(ed));
        check($sformatf("err op%h", op), 64'(out_err), 64'(ee));
        finish_op();
    endtask

    task automatic run_directed(input string name, input logic [5:0] op, input logic [1:0] ww,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] er, input logic [7:0] ed,
                                input logic ee, input int el);
        int lat;
        start_op(op, ww, a, b);
        wait_result(lat);
        check({name, "_lat"}, 64'(lat), 64'(el));
        check({name, "_res"}, out_result, er);
        check({name, "_dz"}, 64'(out_dz), 64'(ed));
        check({name, "_err"}, 64'(out_err), 64'(ee));
        finish_op();
    endtask

    initial begin
        logic [63:0] a, b, er, mask;
        logic [7:0]  ed;
        logic        ee, saw;
        logic [5:0]  op;
        logic [1:0]  ww;
        int          el, lat, w, sel;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", out_result, 64'd0);
        check("rst_dz", 64'(out_dz), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check("post_rst_ready", 64'(in_ready), 64'd1);

        run_directed("div8", c_VDIV, 2'b00, 64'hC864FF0700102030, 64'h0A03100205040007,
                     64'h14210F030004FF06, 8'b00000010, 1'b0, 73);
        run_directed("mod64", c_VMOD, 2'b11, 64'd100, 64'd7, 64'd2, 8'h00, 1'b0, 66);
        run_directed("mod64_dz", c_VMOD, 2'b11, 64'd100, 64'd0, 64'd100, 8'hFF, 1'b0, 66);
        run_directed("sqrt16", c_VSQRT, 2'b01, 64'hFFFF001000000190, 64'd0,
                     64'h00FF000400000014, 8'h00, 1'b0, 37);
        run_directed("illegal", 6'b000110, 2'b00, 64'h1234, 64'h5678, 64'd0, 8'h00, 1'b1, 1);

        // Backpressure: result held while out_ready is low; offers meanwhile are dropped.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom} >> 8;
        model(c_VDIV, 2'b01, a, b, er, ed, ee, el);
        start_op(c_VDIV, 2'b01, a, b);
        wait_result(lat);
        check("bp_lat", 64'(lat), 64'(el));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = c_VSQRT; in_ww = 2'b01; in_a = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", out_result, er);
            check("bp_dz", 64'(out_dz), 64'(ed));
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk) in_valid = 1'b0;
        finish_op();
        saw = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1 if (out_valid) saw = 1'b1;
        end
        check("bp_no_queue", 64'(saw), 64'd0);
        run_rand(c_VMOD, 2'b10, {$urandom, $urandom}, {$urandom, $urandom} >> 4);

        // Asynchronous reset in the middle of an op.
        start_op(c_VDIV, 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h0101010101010101);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_result", out_result, 64'd0);
        check("mid_rst_dz", 64'(out_dz), 64'd0);
        check("mid_rst_err", 64'(out_err), 64'd0);
        @(negedge clk) reset = 1'b0;
        run_directed("div32", c_VDIV, 2'b10, 64'h000000640000000A, 64'h0000000A00000003,
                     64'h0000000A00000003, 8'h00, 1'b0, 67);

        // Flush during an op.
        start_op(c_VDIV, 2'b00, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (4) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        saw = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1 if (out_valid) saw = 1'b1;
        end
        check("flush_no_result", 64'(saw), 64'd0);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: op = c_VDIV;
                3, 4, 5: op = c_VMOD;
                6, 7, 8: op = c_VSQRT;
                default: op = ($urandom_range(0, 1) == 0) ? 6'b111111 : 6'b010011;
            endcase
            ww = 2'($urandom_range(0, 3));
            w  = 8 << ww;
            mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            for (int i = 0; i < 64 / w; i++)
                if ($urandom_range(0, 3) == 0) b &= ~(mask << (64 - (i + 1) * w));
            run_rand(op, ww, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
